// File: rtl/prbs_checker.sv
// prbs_checker: receive-side checker for the x^4 + x + 1 PRBS stream.
// The checker seeds a local LFSR from the first four received bits and then
// predicts every following bit. It reports lock status, a per-bit error
// strobe, and saturating error and bit counters.
module prbs_checker #(
    parameter int ERR_W       = 16,
    parameter int LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] bit_count
);

    typedef enum logic {
        SEED   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [3:0]       THRESH  = 4'(LOSS_THRESH);
    localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};

    state_t           state_reg, state_next;
    logic [3:0]       sr_reg, sr_next;
    logic [2:0]       fill_reg, fill_next;
    logic [3:0]       miss_reg, miss_next;
    logic             err_pulse_reg, err_pulse_next;
    logic [ERR_W-1:0] err_count_reg, err_count_next;
    logic [ERR_W-1:0] bit_count_reg, bit_count_next;

    // Predicted bit, the seed-shifted register, and the qualified events
    logic       exp_bit;
    logic [3:0] seed_shift;
    logic       bit_inc;
    logic       err_inc;

    assign exp_bit    = sr_reg[0] ^ sr_reg[1];
    assign seed_shift = {din, sr_reg[3:1]};
    assign bit_inc    = din_valid && (state_reg == LOCKED);
    assign err_inc    = bit_inc && (din != exp_bit);

    // State register: every piece of state clears asynchronously on clr_n
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg     <= SEED;
            sr_reg        <= 4'h0;
            fill_reg      <= 3'd0;
            miss_reg      <= 4'd0;
            err_pulse_reg <= 1'b0;
            err_count_reg <= '0;
            bit_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sr_reg        <= sr_next;
            fill_reg      <= fill_next;
            miss_reg      <= miss_next;
            err_pulse_reg <= err_pulse_next;
            err_count_reg <= err_count_next;
            bit_count_reg <= bit_count_next;
        end
    end

    // Next-state logic: seeding, prediction, and loss-of-lock decisions
    always_comb begin
        state_next     = state_reg;
        sr_next        = sr_reg;
        fill_next      = fill_reg;
        miss_next      = miss_reg;
        err_pulse_next = 1'b0;
        if (din_valid) begin
            case (state_reg)
                SEED: begin
                    if (fill_reg == 3'd3) begin
                        // An all-zero seed would lock the LFSR at zero, so
                        // it is thrown away and collection starts over.
                        fill_next = 3'd0;
                        if (seed_shift != 4'h0) begin
                            sr_next    = seed_shift;
                            state_next = LOCKED;
                        end else begin
                            sr_next = 4'h0;
                        end
                    end else begin
                        sr_next   = seed_shift;
                        fill_next = fill_reg + 3'd1;
                    end
                end
                LOCKED: begin
                    // The predictor advances on its own bit so that line
                    // errors never corrupt it.
                    sr_next = {exp_bit, sr_reg[3:1]};
                    if (err_inc) begin
                        err_pulse_next = 1'b1;
                        if (miss_reg + 4'd1 == THRESH) begin
                            state_next = SEED;
                            sr_next    = 4'h0;
                            fill_next  = 3'd0;
                            miss_next  = 4'd0;
                        end else begin
                            miss_next = miss_reg + 4'd1;
                        end
                    end else begin
                        miss_next = 4'd0;
                    end
                end
                default: state_next = SEED;
            endcase
        end
    end

    // Saturating counters; a clear wins over a simultaneous increment
    always_comb begin
        err_count_next = err_count_reg;
        bit_count_next = bit_count_reg;
        if (clear_cnt) begin
            err_count_next = '0;
            bit_count_next = '0;
        end else begin
            if (err_inc && (err_count_reg != CNT_MAX)) begin
                err_count_next = err_count_reg + 1'b1;
            end
            if (bit_inc && (bit_count_reg != CNT_MAX)) begin
                bit_count_next = bit_count_reg + 1'b1;
            end
        end
    end

    // Outputs come straight from registers
    always_comb begin
        locked    = (state_reg == LOCKED);
        err_pulse = err_pulse_reg;
        err_count = err_count_reg;
        bit_count = bit_count_reg;
    end

endmodule
